// File: rtl/rggen_register_bus_arbiter_pkg.sv
// Shared constants for the register-bus arbiter: response status codes,
// controller state encodings and an index-width helper.
package rggen_register_bus_arbiter_pkg;

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY = 2'b01;
    localparam logic [1:0] STATUS_SLVERR = 2'b10;
    localparam logic [1:0] STATUS_DECERR = 2'b11;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_ISSUE   = 2'd1;
    localparam logic [1:0] STATE_RESPOND = 2'd2;

    // Width of a binary host index; never narrower than one bit.
    function automatic int index_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin picker: first requester searching upward from
// the host after last_grant, wrapping at HOST_COUNT.
module rggen_round_robin_arbiter
    import rggen_register_bus_arbiter_pkg::*;
#(
    parameter int HOST_COUNT = 2
)(
    input  logic [HOST_COUNT-1:0]                 request,
    input  logic [index_width(HOST_COUNT)-1:0]    last_grant,
    output logic [HOST_COUNT-1:0]                 grant,
    output logic [index_width(HOST_COUNT)-1:0]    grant_index
);

    localparam int INDEX_WIDTH = index_width(HOST_COUNT);

    always_comb begin
        logic                   found;
        logic [INDEX_WIDTH-1:0] candidate;
        found       = 1'b0;
        candidate   = '0;
        grant       = '0;
        grant_index = '0;
        for (int i = 1; i <= HOST_COUNT; i++) begin
            candidate = INDEX_WIDTH'((int'(last_grant) + i) % HOST_COUNT);
            if (!found && request[candidate]) begin
                found              = 1'b1;
                grant[candidate]   = 1'b1;
                grant_index        = candidate;
            end
        end
    end

endmodule

// File: rtl/rggen_register_bus_arbiter.sv
// Shares one rggen register-block bus among HOST_COUNT hosts with round-robin
// arbitration, a single outstanding transaction and an optional watchdog.
module rggen_register_bus_arbiter
    import rggen_register_bus_arbiter_pkg::*;
#(
    parameter int HOST_COUNT     = 2,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 0
)(
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [HOST_COUNT-1:0]               i_host_valid,
    input  logic [2*HOST_COUNT-1:0]             i_host_access,
    input  logic [ADDRESS_WIDTH*HOST_COUNT-1:0] i_host_address,
    input  logic [BUS_WIDTH*HOST_COUNT-1:0]     i_host_write_data,
    input  logic [BUS_WIDTH/8*HOST_COUNT-1:0]   i_host_strobe,
    output logic [HOST_COUNT-1:0]               o_host_ready,
    output logic [1:0]                          o_host_status,
    output logic [BUS_WIDTH-1:0]                o_host_read_data,
    output logic                                o_register_valid,
    output logic [1:0]                          o_register_access,
    output logic [ADDRESS_WIDTH-1:0]            o_register_address,
    output logic [BUS_WIDTH-1:0]                o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]              o_register_strobe,
    input  logic                                i_register_ready,
    input  logic [1:0]                          i_register_status,
    input  logic [BUS_WIDTH-1:0]                i_register_read_data
);

    localparam int STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int INDEX_WIDTH  = index_width(HOST_COUNT);

    logic [1:0]             state;
    logic [INDEX_WIDTH-1:0] last_grant;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic [INDEX_WIDTH-1:0] active_index;
    logic [HOST_COUNT-1:0]  grant;
    logic [HOST_COUNT-1:0]  active_grant;
    logic                   timeout;

    rggen_round_robin_arbiter #(
        .HOST_COUNT (HOST_COUNT)
    ) u_arbiter (
        .request     (i_host_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_index (grant_index)
    );

    // Watchdog only counts ISSUE cycles without a register-block answer.
    if (TIMEOUT_CYCLES != 0) begin : g_watchdog
        localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;
        logic [COUNT_WIDTH-1:0] count;

        assign timeout = (state == STATE_ISSUE) &&
                         (count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                count <= '0;
            end else if (state == STATE_RESPOND) begin
                count <= '0;
            end else if (state == STATE_ISSUE && !i_register_ready && !timeout) begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end else begin : g_no_watchdog
        assign timeout = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state                 <= STATE_IDLE;
            last_grant            <= INDEX_WIDTH'(HOST_COUNT - 1);
            active_index          <= '0;
            active_grant          <= '0;
            o_register_valid      <= 1'b0;
            o_register_access     <= '0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_strobe     <= '0;
            o_host_ready          <= '0;
            o_host_status         <= '0;
            o_host_read_data      <= '0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (|i_host_valid) begin
                        o_register_valid      <= 1'b1;
                        o_register_access     <= i_host_access[2*int'(grant_index) +: 2];
                        o_register_address    <= i_host_address[ADDRESS_WIDTH*int'(grant_index) +: ADDRESS_WIDTH];
                        o_register_write_data <= i_host_write_data[BUS_WIDTH*int'(grant_index) +: BUS_WIDTH];
                        o_register_strobe     <= i_host_strobe[STROBE_WIDTH*int'(grant_index) +: STROBE_WIDTH];
                        active_index          <= grant_index;
                        active_grant          <= grant;
                        state                 <= STATE_ISSUE;
                    end
                end
                STATE_ISSUE: begin
                    // A real answer takes precedence over a coinciding timeout.
                    if (i_register_ready) begin
                        o_register_valid <= 1'b0;
                        o_host_ready     <= active_grant;
                        o_host_status    <= i_register_status;
                        o_host_read_data <= i_register_read_data;
                        state            <= STATE_RESPOND;
                    end else if (timeout) begin
                        o_register_valid <= 1'b0;
                        o_host_ready     <= active_grant;
                        o_host_status    <= STATUS_SLVERR;
                        o_host_read_data <= '0;
                        state            <= STATE_RESPOND;
                    end
                end
                STATE_RESPOND: begin
                    o_host_ready     <= '0;
                    o_host_status    <= '0;
                    o_host_read_data <= '0;
                    last_grant       <= active_index;
                    state            <= STATE_IDLE;
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level
// reference model for the two-host register-bus arbiter.
module tb_rggen_register_bus_arbiter;

    localparam int HC = 2;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int SW = BW / 8;
    localparam int TO = 4;

    logic           clk;
    logic           rst;
    logic [HC-1:0]  hv;
    logic [2*HC-1:0] h_access;
    logic [AW*HC-1:0] h_address;
    logic [BW*HC-1:0] h_wdata;
    logic [SW*HC-1:0] h_strobe;
    logic [HC-1:0]  o_host_ready;
    logic [1:0]     o_host_status;
    logic [BW-1:0]  o_host_read_data;
    logic           o_register_valid;
    logic [1:0]     o_register_access;
    logic [AW-1:0]  o_register_address;
    logic [BW-1:0]  o_register_write_data;
    logic [SW-1:0]  o_register_strobe;
    logic           reg_ready;
    logic [1:0]     reg_status;
    logic [BW-1:0]  reg_rdata;

    int compared;
    int mismatched;

    rggen_register_bus_arbiter #(
        .HOST_COUNT     (HC),
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_host_valid          (hv),
        .i_host_access         (h_access),
        .i_host_address        (h_address),
        .i_host_write_data     (h_wdata),
        .i_host_strobe         (h_strobe),
        .o_host_ready          (o_host_ready),
        .o_host_status         (o_host_status),
        .o_host_read_data      (o_host_read_data),
        .o_register_valid      (o_register_valid),
        .o_register_access     (o_register_access),
        .o_register_address    (o_register_address),
        .o_register_write_data (o_register_write_data),
        .o_register_strobe     (o_register_strobe),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    function automatic logic [46:0] req_bundle();
        return {o_register_valid, o_register_access, o_register_address,
                o_register_write_data, o_register_strobe};
    endfunction

    function automatic logic [35:0] resp_bundle();
        return {o_host_ready, o_host_status, o_host_read_data};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; hv = '0; reg_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; hv = 2'b11; reg_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (req_bundle() !== 47'd0) begin
            mismatched++;
            $display("FAIL reset_req: got %h required 0", req_bundle());
        end
        compared++;
        if (resp_bundle() !== 36'd0) begin
            mismatched++;
            $display("FAIL reset_resp: got %h required 0", resp_bundle());
        end
        rst = 1'b0; hv = '0; reg_ready = 1'b0;
        @(negedge clk);
        compared++;
        if (o_register_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_idle: got valid %b required 0", o_register_valid);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        h_access = 4'b0000; h_address = {8'h10, 8'h77}; h_wdata = '0; h_strobe = '0;
        hv = 2'b10;
        @(negedge clk);
        compared++;
        if ({o_register_valid, o_register_address, o_host_ready} !== {1'b1, 8'h10, 2'b00}) begin
            mismatched++;
            $display("FAIL read_issue1: got v=%b a=%h r=%b required v=1 a=10 r=00",
                     o_register_valid, o_register_address, o_host_ready);
        end
        @(negedge clk);
        compared++;
        if (o_register_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL read_issue2: got valid %b required 1", o_register_valid);
        end
        reg_ready = 1'b1; reg_status = 2'b00; reg_rdata = 32'hA5A5_0001;
        @(negedge clk);
        compared++;
        if ({o_register_valid, resp_bundle()} !== {1'b0, 2'b10, 2'b00, 32'hA5A5_0001}) begin
            mismatched++;
            $display("FAIL read_resp: got v=%b resp=%h required v=0 resp=%h",
                     o_register_valid, resp_bundle(), {2'b10, 2'b00, 32'hA5A5_0001});
        end
        reg_ready = 1'b0; hv = '0;
        @(negedge clk);
        compared++;
        if (resp_bundle() !== 36'd0) begin
            mismatched++;
            $display("FAIL read_pulse: got %h required 0", resp_bundle());
        end
    endtask

    task automatic test_simultaneous();
        int cnt0, cnt1, exp_h;
        do_reset();
        cnt0 = 0; cnt1 = 0; exp_h = 0;
        h_access = $urandom; h_address = $urandom; h_wdata = {$urandom, $urandom}; h_strobe = $urandom;
        hv = 2'b11; reg_ready = 1'b1; reg_status = 2'b00; reg_rdata = $urandom;
        for (int c = 0; c < 60 && (cnt0 < 4 || cnt1 < 4); c++) begin
            @(negedge clk);
            if (o_host_ready !== 2'b00) begin
                compared++;
                if (o_host_ready !== (2'b01 << exp_h)) begin
                    mismatched++;
                    $display("FAIL rr_order: got %b required %b", o_host_ready, 2'b01 << exp_h);
                end
                if (o_host_ready[0]) begin cnt0++; if (cnt0 >= 4) hv[0] = 1'b0; end
                if (o_host_ready[1]) begin cnt1++; if (cnt1 >= 4) hv[1] = 1'b0; end
                exp_h = 1 - exp_h;
            end
        end
        compared++;
        if (cnt0 !== 4 || cnt1 !== 4) begin
            mismatched++;
            $display("FAIL rr_count: got %0d/%0d required 4/4", cnt0, cnt1);
        end
        hv = '0; reg_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        logic [46:0] exp_req;
        do_reset();
        h_access = {2'b10, 2'b01}; h_address = {8'h99, 8'h04};
        h_wdata = {32'h1234_5678, 32'hDEAD_BEEF}; h_strobe = {4'b1111, 4'b0011};
        reg_rdata = 32'h1111_2222; reg_status = 2'b00;
        hv = 2'b01;
        exp_req = {1'b1, 2'b01, 8'h04, 32'hDEAD_BEEF, 4'b0011};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared++;
            if (req_bundle() !== exp_req) begin
                mismatched++;
                $display("FAIL write_hold%0d: got %h required %h", c, req_bundle(), exp_req);
            end
            if (c == 0) begin
                hv = '0; h_access = '1; h_address = '1; h_wdata = '1; h_strobe = '1;
            end
            if (c == 2) reg_ready = 1'b1;
        end
        @(negedge clk);
        compared++;
        if ({o_register_valid, resp_bundle()} !== {1'b0, 2'b01, 2'b00, 32'h1111_2222}) begin
            mismatched++;
            $display("FAIL write_resp: got v=%b resp=%h required v=0 resp=%h",
                     o_register_valid, resp_bundle(), {2'b01, 2'b00, 32'h1111_2222});
        end
        reg_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        do_reset();
        h_access = '0; h_address = {8'h30, 8'h20}; h_wdata = '0; h_strobe = '0;
        reg_ready = 1'b0; reg_status = 2'b01; reg_rdata = 32'hBADB_AD00;
        hv = 2'b01;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            hv = '0;
            compared++;
            if (o_register_valid !== 1'b1 || o_host_ready !== 2'b00) begin
                mismatched++;
                $display("FAIL to_valid%0d: got v=%b r=%b required v=1 r=00", c, o_register_valid, o_host_ready);
            end
        end
        @(negedge clk);
        compared++;
        if ({o_register_valid, resp_bundle()} !== {1'b0, 2'b01, 2'b10, 32'h0}) begin
            mismatched++;
            $display("FAIL to_slverr: got v=%b resp=%h required v=0 resp=%h",
                     o_register_valid, resp_bundle(), {2'b01, 2'b10, 32'h0});
        end
        @(negedge clk);
        compared++;
        if (resp_bundle() !== 36'd0) begin
            mismatched++;
            $display("FAIL to_pulse: got %h required 0", resp_bundle());
        end
        hv = 2'b10;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            hv = '0;
            compared++;
            if (o_register_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL to_late_valid%0d: got %b required 1", c, o_register_valid);
            end
        end
        reg_ready = 1'b1; reg_status = 2'b01; reg_rdata = 32'h0C0F_FEE0;
        @(negedge clk);
        compared++;
        if (resp_bundle() !== {2'b10, 2'b01, 32'h0C0F_FEE0}) begin
            mismatched++;
            $display("FAIL to_ready_wins: got %h required %h", resp_bundle(), {2'b10, 2'b01, 32'h0C0F_FEE0});
        end
        reg_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        h_access = '0; h_address = {8'h22, 8'h11}; h_wdata = '0; h_strobe = '0;
        reg_status = 2'b00; reg_rdata = 32'h0;
        hv = 2'b01;
        @(negedge clk);
        hv = '0; reg_ready = 1'b1;
        @(negedge clk);
        reg_ready = 1'b0;
        @(negedge clk);
        hv = 2'b10;
        @(negedge clk);
        compared++;
        if ({o_register_valid, o_register_address} !== {1'b1, 8'h22}) begin
            mismatched++;
            $display("FAIL mid_grant1: got v=%b a=%h required v=1 a=22", o_register_valid, o_register_address);
        end
        rst = 1'b1; hv = '0; reg_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({req_bundle(), resp_bundle()} !== 83'd0) begin
            mismatched++;
            $display("FAIL mid_reset: got %h required 0", {req_bundle(), resp_bundle()});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared++;
            if (o_host_ready !== 2'b00 || o_register_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL mid_abandon%0d: got r=%b v=%b required r=00 v=0", c, o_host_ready, o_register_valid);
            end
        end
        reg_ready = 1'b0; hv = 2'b11;
        @(negedge clk);
        hv = '0;
        compared++;
        if ({o_register_valid, o_register_address} !== {1'b1, 8'h11}) begin
            mismatched++;
            $display("FAIL mid_host0_first: got v=%b a=%h required v=1 a=11", o_register_valid, o_register_address);
        end
        reg_ready = 1'b1;
        @(negedge clk);
        reg_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_error();
        do_reset();
        h_access = 4'b0000; h_address = {8'h00, 8'hFC}; h_wdata = '0; h_strobe = '0;
        hv = 2'b01;
        @(negedge clk);
        hv = '0;
        compared++;
        if ({o_register_valid, o_register_address} !== {1'b1, 8'hFC}) begin
            mismatched++;
            $display("FAIL err_issue: got v=%b a=%h required v=1 a=fc", o_register_valid, o_register_address);
        end
        reg_ready = 1'b1; reg_status = 2'b11; reg_rdata = 32'h5EED_1234;
        @(negedge clk);
        compared++;
        if (resp_bundle() !== {2'b01, 2'b11, 32'h5EED_1234}) begin
            mismatched++;
            $display("FAIL err_decerr: got %h required %h", resp_bundle(), {2'b01, 2'b11, 32'h5EED_1234});
        end
        reg_ready = 1'b0;
        @(negedge clk);
    endtask

    // Reference model: tracks the outstanding transaction as "waiting for the
    // register block" / "answer being delivered" and derives expected outputs.
    task automatic test_random();
        logic [46:0] exp_req;
        logic [35:0] exp_resp;
        bit          m_waiting, m_answering;
        int          m_cycles, m_last, m_owner, w;
        do_reset();
        exp_req = '0; exp_resp = '0;
        m_waiting = 0; m_answering = 0; m_cycles = 0; m_last = HC - 1; m_owner = 0;
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 79) == 0);
            hv         = HC'($urandom_range(0, 3));
            h_access   = 4'($urandom);
            h_address  = 16'($urandom);
            h_wdata    = {$urandom, $urandom};
            h_strobe   = 8'($urandom);
            reg_ready  = o_register_valid ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1;
            reg_status = 2'($urandom);
            reg_rdata  = $urandom;
            if (rst) begin
                exp_req = '0; exp_resp = '0;
                m_waiting = 0; m_answering = 0; m_cycles = 0; m_last = HC - 1;
            end else if (m_answering) begin
                m_answering = 0;
                m_last      = m_owner;
                exp_resp    = '0;
            end else if (m_waiting) begin
                if (reg_ready) begin
                    m_waiting = 0; m_answering = 1;
                    exp_req[46] = 1'b0;
                    exp_resp    = {2'b01 << m_owner, reg_status, reg_rdata};
                end else if (m_cycles + 1 == TO) begin
                    m_waiting = 0; m_answering = 1;
                    exp_req[46] = 1'b0;
                    exp_resp    = {2'b01 << m_owner, 2'b10, 32'h0};
                end else begin
                    m_cycles++;
                end
            end else if (hv != '0) begin
                w = (m_last + 1) % HC;
                if (!hv[w]) w = (w + 1) % HC;
                m_owner   = w;
                m_waiting = 1;
                m_cycles  = 0;
                exp_req   = {1'b1, h_access[2*w +: 2], h_address[AW*w +: AW],
                             h_wdata[BW*w +: BW], h_strobe[SW*w +: SW]};
            end
            @(negedge clk);
            compared++;
            if (req_bundle() !== exp_req) begin
                mismatched++;
                $display("FAIL rand_req c=%0d: got %h required %h", c, req_bundle(), exp_req);
            end
            compared++;
            if (resp_bundle() !== exp_resp) begin
                mismatched++;
                $display("FAIL rand_resp c=%0d: got %h required %h", c, resp_bundle(), exp_resp);
            end
        end
        rst = 1'b0; hv = '0; reg_ready = 1'b0;
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1; hv = '0; h_access = '0; h_address = '0; h_wdata = '0; h_strobe = '0;
        reg_ready = 1'b0; reg_status = '0; reg_rdata = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_write();
        test_timeout();
        test_reset_mid();
        test_error();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
